// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] RD_HI = 2'b01;
    localparam logic [1:0] RD_LO = 2'b10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the full {hi,lo} result.
module mdu_calc
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         md_op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic [2*WIDTH-1:0] result,
    output logic               div0
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          div_s;
    logic [WIDTH-1:0]          div_u;
    logic [WIDTH-1:0]          quot_s;
    logic [WIDTH-1:0]          rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;
    logic                      ovf;

    assign prod_s = $signed({{WIDTH{rs[WIDTH-1]}}, rs}) * $signed({{WIDTH{rt[WIDTH-1]}}, rt});
    assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

    assign div0 = (rt == '0);
    // Most-negative / -1 overflows; dividing by 1 instead yields the required
    // quotient (the dividend itself) and a zero remainder.
    assign ovf  = (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == '1);

    // Substitute divisors keep the dividers well defined; div0 suppresses the commit.
    assign div_s = (div0 || ovf) ? WIDTH'(1) : rt;
    assign div_u = div0 ? WIDTH'(1) : rt;

    assign quot_s = $signed(rs) / $signed(div_s);
    assign rem_s  = $signed(rs) % $signed(div_s);
    assign quot_u = rs / div_u;
    assign rem_u  = rs % div_u;

    // Select the result for the requested operation as {hi, lo}.
    always_comb begin
        result = '0;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quot_s};
            MD_DIVU:  result = {rem_u, quot_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: latency sequencing, HI/LO ownership, mfhi/mflo reads and D-stage stall.
//   state  | meaning
//   S_IDLE | accepts start or mthi/mtlo; HI/LO hold committed values
//   S_BUSY | counting down the op latency; pending result commits on 1->0
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilowe,
    input  logic             hilo_A3,
    input  logic [1:0]       re_hi_loop,
    input  logic             d_stall_busy,
    output logic             busy,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             stall_req
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   pend_hi, pend_lo;
    logic               pend_keep;
    logic [2*WIDTH-1:0] calc_result;
    logic               calc_div0;
    logic               accept;
    logic               mt_write;
    logic               last_cycle;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .md_op  (md_op),
        .rs     (rs_val),
        .rt     (rt_val),
        .result (calc_result),
        .div0   (calc_div0)
    );

    assign accept     = (state == S_IDLE) && start && !hilowe;
    assign mt_write   = (state == S_IDLE) && hilowe && !start;
    assign last_cycle = (state == S_BUSY) && (cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_BUSY;
            S_BUSY:  if (last_cycle) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_keep <= 1'b0;
        end else if (accept) begin
            cnt       <= md_op[1] ? DIV_LOAD : MULT_LOAD;
            pend_hi   <= calc_result[2*WIDTH-1:WIDTH];
            pend_lo   <= calc_result[WIDTH-1:0];
            pend_keep <= md_op[1] && calc_div0;
        end else if (state == S_BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (last_cycle && !pend_keep) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (mt_write) begin
            if (hilo_A3) lo <= rs_val;
            else         hi <= rs_val;
        end
    end

    assign busy      = (state == S_BUSY);
    assign stall_req = d_stall_busy && (start || busy);

    // mfhi/mflo read mux.
    always_comb begin
        hilo_rd = '0;
        case (re_hi_loop)
            RD_HI:   hilo_rd = hi;
            RD_LO:   hilo_rd = lo;
            default: hilo_rd = '0;
        endcase
    end

    // Illegal combinations are ignored by the logic above; the D-stage stall should prevent them.
    a_no_start_and_write: assert property (@(posedge clk) disable iff (!reset) !(start && hilowe));
    a_no_start_busy:      assert property (@(posedge clk) disable iff (!reset) !(start && busy));
    a_no_write_busy:      assert property (@(posedge clk) disable iff (!reset) !(hilowe && busy));

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit and HI/LO register owner for the E stage of the 5-stage MIPS pipeline. It accepts mult/multu/div/divu starts and mthi/mtlo writes from E, sequences the fixed multi-cycle latency, and drives the busy indication. It also serves mfhi/mflo reads and generates the D-stage stall request for HI/LO-touching instructions.

Parameters:
WIDTH, 32, operand/HI/LO width.
MULT_CYCLES, 5, busy cycles for mult/multu.
DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse.
md_op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu; valid when start=1.
rs_val  in  WIDTH  forwarded rs operand (E stage).
rt_val  in  WIDTH  forwarded rt operand (E stage).
hilowe  in  1  mthi/mtlo write enable (E stage).
hilo_A3  in  1  write target: 0 = HI, 1 = LO.
re_hi_loop  in  2  read select: 01 = HI, 10 = LO, other = none.
d_stall_busy  in  1  D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
busy  out  1  operation in progress.
hilo_rd  out  WIDTH  mfhi/mflo read data.
stall_req  out  1  stall D-stage request.

Behaviour:
- States: IDLE, BUSY. Down-counter cnt has $clog2(max(MULT_CYCLES, DIV_CYCLES)+1) bits.
- Reset (reset=0, async): state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending result=0. Reset asserted mid-BUSY aborts the operation. HI/LO become 0, not the pending result.
- IDLE + start at a rising edge:
  - Compute the result from rs_val/rt_val into pending registers.
  - Load cnt with MULT_CYCLES or DIV_CYCLES. Move to BUSY.
  - HI/LO are unchanged at this edge.
- BUSY: busy=1 and cnt decrements each edge. At the edge where cnt goes 1->0, commit pending to HI/LO and go to IDLE.
- busy timing: low in the start cycle. High for exactly N cycles beginning the cycle after start. The first cycle with busy=0 sees the new HI/LO.
- Arithmetic, all 2*WIDTH products:
  - mult: signed product {HI,LO}.
  - multu: unsigned product {HI,LO}.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (div or divu): the operation still takes DIV_CYCLES with busy=1. HI and LO keep their prior values.
- hilowe in IDLE with start=0: write rs_val to HI (hilo_A3=0) or LO (hilo_A3=1) at the edge, visible the next cycle.
- Illegal inputs: start and hilowe both 1, start while BUSY, or hilowe while BUSY. These are ignored, with no state change, and flagged by a simulation assertion. The D-stage stall prevents them.
- hilo_rd (combinational from current HI/LO): HI when re_hi_loop=01, LO when 10, else 0. An mfhi/mflo issued the cycle after an mthi/mtlo reads the written value.
- stall_req = d_stall_busy & (start | busy), combinational.
  - Not asserted in the commit-edge's following cycle. busy is already 0 then.

Decomposition:
- Shared define package holds the md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the re_hi_loop encodings (RD_HI=2'b01, RD_LO=2'b10), and the MULT_CYCLES/DIV_CYCLES defaults.
- One sub-module, mdu_calc: purely combinational; takes md_op/rs/rt and produces the 64-bit {hi,lo} result and a div0 flag. mdu_ctrl holds the FSM, counter, HI/LO and the stall logic.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3 -> busy high for cycles 1..5 after start; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles. div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu rs=0xFFFFFFF9, rt=2 -> LO=0x7FFFFFFC, HI=0x00000001. div with rt=0 after mthi 0x1234 and mtlo 0x5678 -> 10 busy cycles, then HI=0x1234, LO=0x5678 unchanged.
- mtlo 0xCAFEBABE, then next cycle mflo (re_hi_loop=10) -> hilo_rd=0xCAFEBABE. re_hi_loop=00 -> hilo_rd=0.
- start mult with d_stall_busy=1 held -> stall_req=1 for the start cycle plus 5 busy cycles (6 total), 0 on the next.
- Drop reset for 1 ns during cycle 3 of a div -> busy=0, HI=LO=0 immediately. After release: IDLE, and a new start is accepted.
